// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR stream sequencer.
//   sample_t     - 16-bit signed audio sample / filtered result
//   seq_state_t  - sequencer FSM state encoding
//   FIR_TAPS     - tap count of the companion FIR engine
//   FIR_LATENCY  - cycles from the issue cycle to the engine's done pulse
package fir_pkg;

    localparam int FIR_TAPS    = 16;
    localparam int FIR_LATENCY = 18;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } seq_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: small input buffer for the FIR sequencer.
//   ck, rst_n  - clock, asynchronous active-low reset
//   push       - write request, ignored while full
//   push_data  - sample to write
//   pop        - read request, ignored while empty; advances the head
//   head       - oldest stored sample, read from registered storage
//   full/empty - derived from the occupancy count
module sample_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               push,
    input  logic signed [15:0] push_data,
    input  logic               pop,
    output logic signed [15:0] head,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge ck) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: stream-side controller for the 16-tap FIR engine.
//   ck, rst_n          - clock, asynchronous active-low reset
//   s_data/s_valid/s_ready - input sample handshake (buffered in a FIFO)
//   m_data/m_valid/m_ready - filtered result, held until accepted
//   fir_in, fir_start  - sample and one-cycle start pulse to the engine
//   fir_out, fir_done  - engine result and completion pulse
//   busy               - FSM active or samples pending
//   timeout_err/err_clr - sticky watchdog flag and its clear
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic signed [15:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic signed [15:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [15:0] fir_in,
    output logic               fir_start,
    input  logic signed [15:0] fir_out,
    input  logic               fir_done,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int TW         = $clog2(TIMEOUT);
    localparam int TIMER_LAST = TIMEOUT - 1;
    localparam logic [TW-1:0] TIMER_END = TIMER_LAST[TW-1:0];

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [TW-1:0] timer;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    sample_t       fifo_head;

    logic          slot_free;
    logic          timer_clr;
    logic          timer_inc;
    logic          wd_fire;
    logic          capture;

    assign s_ready   = !fifo_full;
    assign slot_free = !m_valid || m_ready;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck        (ck),
        .rst_n     (rst_n),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // A pop is only taken when the output slot will be free, so CAPTURE
    // never overwrites a result the sink has not yet accepted.
    always_comb begin
        state_nx  = state;
        fifo_pop  = 1'b0;
        fir_start = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        wd_fire   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fir_start = 1'b1;
                timer_clr = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                if (fir_done) begin
                    state_nx = ST_CAPTURE;
                end else if (timer == TIMER_END) begin
                    wd_fire  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_CAPTURE: begin
                capture  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // fir_in is only written on a pop, so it stays stable through ISSUE and
    // the engine's load cycle that follows.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            fir_in <= '0;
            timer  <= '0;
        end else begin
            if (fifo_pop)       fir_in <= fifo_head;
            if (timer_clr)      timer  <= '0;
            else if (timer_inc) timer  <= timer + 1'b1;
        end
    end

    // The engine registers its result on the done cycle, so the value is
    // sampled one cycle later in CAPTURE.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (capture) begin
            m_data  <= fir_out;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // A new timeout takes priority over a coincident clear.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)       timeout_err <= 1'b0;
        else if (wd_fire) timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed bench for fir_sequencer with a behavioural
// engine stub (result = arithmetic negation of the loaded sample, done
// pulse 18 cycles after the start pulse, done can be suppressed).
module tb_fir_sequencer;

    logic               ck = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] fir_in;
    logic               fir_start;
    logic signed [15:0] fir_out;
    logic               fir_done;
    logic               busy;
    logic               timeout_err;
    logic               err_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt = 0;

    logic signed [15:0] got_data[$];
    int                 got_cyc[$];

    always #5 ck = ~ck;

    fir_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (31)
    ) dut (
        .ck          (ck),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fir_in      (fir_in),
        .fir_start   (fir_start),
        .fir_out     (fir_out),
        .fir_done    (fir_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    // Engine stub: loads fir_in one cycle after start, done 18 cycles after start.
    logic [4:0]         eng_cnt;
    logic signed [15:0] eng_smp;
    logic               eng_done_en = 1'b1;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt <= '0;
            eng_smp <= '0;
            fir_out <= '0;
        end else if (fir_start) begin
            eng_cnt <= 5'd1;
        end else if (eng_cnt != 5'd0) begin
            if (eng_cnt == 5'd1) eng_smp <= fir_in;
            if (eng_cnt == 5'd18) begin
                eng_cnt <= '0;
                fir_out <= -eng_smp;
            end else begin
                eng_cnt <= eng_cnt + 5'd1;
            end
        end
    end
    assign fir_done = eng_done_en && (eng_cnt == 5'd18);

    // Edge-index counter plus result/start collector.
    always @(posedge ck) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            if (fir_start) start_cnt++;
        end
        cyc++;
    end

    typedef struct {
        logic signed [15:0] smp;
        logic signed [15:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns the index of the edge that takes the push.
    task automatic push(input logic signed [15:0] d, output int pcyc, output bit saw_full);
        int n;
        n = 0;
        saw_full = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            saw_full = 1;
            @(negedge ck);
            n++;
        end
        pcyc = cyc;
        @(negedge ck);
        s_valid = 1'b0;
        if (n >= 200) chk("push_accept_timeout", 0, 1);
    endtask

    task automatic wait_mvalid(input int bound, output int c);
        int n;
        n = 0;
        while (!m_valid && n < bound) begin
            @(negedge ck);
            n++;
        end
        c = cyc;
    endtask

    task automatic wait_start(input int bound, output int c);
        int n;
        n = 0;
        while (!fir_start && n < bound) begin
            @(negedge ck);
            n++;
        end
        c = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int p, c, r, s1, s2, e, sc, n, stable_err, d;
        bit sf, any_full;
        logic signed [15:0] hold;

        tbl[0] = '{16'sd100,    -16'sd100};
        tbl[1] = '{-16'sd1,     16'sd1};
        tbl[2] = '{16'sd32767,  -16'sd32767};
        tbl[3] = '{-16'sd32768, -16'sd32768};
        tbl[4] = '{16'sd0,      16'sd0};
        tbl[5] = '{16'sd1234,   -16'sd1234};
        tbl[6] = '{-16'sd5000,  16'sd5000};
        tbl[7] = '{16'sd21845,  -16'sd21845};

        // Reset values
        repeat (3) @(negedge ck);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_fir_in", fir_in, 0);
        chk("rst_fir_start", fir_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Idle with no input
        rst_n = 1'b1;
        repeat (50) @(negedge ck);
        chk("idle_no_start", start_cnt, 0);
        chk("idle_busy", busy, 0);

        // Single-sample latency
        m_ready = 1'b1;
        push(16'sd32767, p, sf);
        wait_mvalid(60, c);
        chk("lat_cycles", c - p, 22);
        chk("lat_data", m_data, -32767);
        @(negedge ck);

        // Burst of 8 through a 4-deep FIFO
        got_data.delete();
        got_cyc.delete();
        any_full = 0;
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].smp, p, sf);
            any_full |= sf;
        end
        chk("burst_sready_drop", any_full, 1);
        n = 0;
        while (got_data.size() < 8 && n < 400) begin
            @(negedge ck);
            n++;
        end
        chk("burst_count", got_data.size(), 8);
        for (int i = 0; i < 8 && i < got_data.size(); i++)
            chk($sformatf("burst_data%0d", i), got_data[i], tbl[i].exp);
        for (int i = 1; i < got_cyc.size(); i++)
            chk($sformatf("burst_spacing%0d", i), got_cyc[i] - got_cyc[i-1], 21);

        // Backpressure
        repeat (5) @(negedge ck);
        m_ready = 1'b0;
        got_data.delete();
        push(16'sd300, p, sf);
        push(-16'sd400, p, sf);
        wait_mvalid(60, c);
        chk("bp_first_data", m_data, -300);
        hold = m_data;
        sc = start_cnt;
        stable_err = 0;
        repeat (100) begin
            @(negedge ck);
            if (m_valid !== 1'b1 || m_data !== hold) stable_err++;
        end
        chk("bp_stable", stable_err, 0);
        chk("bp_no_start", start_cnt - sc, 0);
        m_ready = 1'b1;
        r = cyc;
        wait_start(10, c);
        d = c - r;
        chk("bp_release_issue_within2", (d >= 1 && d <= 2), 1);
        wait_mvalid(40, c);
        chk("bp_second_data", m_data, 400);
        @(negedge ck);
        chk("bp_accepted_count", got_data.size(), 2);

        // Watchdog with a stalled engine
        eng_done_en = 1'b0;
        got_data.delete();
        push(16'sd7, p, sf);
        push(16'sd8, p, sf);
        wait_start(10, s1);
        n = 0;
        while (!timeout_err && n < 60) begin
            @(negedge ck);
            n++;
        end
        e = cyc;
        chk("to_latency", e - s1, 32);
        wait_start(10, s2);
        chk("to_reissue", s2 - s1, 33);
        chk("to_no_result", got_data.size(), 0);
        err_clr = 1'b1;
        @(negedge ck);
        err_clr = 1'b0;
        chk("to_clear", timeout_err, 0);
        n = 0;
        while (cyc < s2 + 31 && n < 60) begin
            @(negedge ck);
            n++;
        end
        err_clr = 1'b1;
        @(negedge ck);
        err_clr = 1'b0;
        chk("to_set_wins", timeout_err, 1);
        repeat (3) @(negedge ck);
        chk("to_idle_busy", busy, 0);

        // Asynchronous reset during WAIT with samples queued
        eng_done_en = 1'b1;
        push(16'sd11, p, sf);
        push(16'sd22, p, sf);
        push(16'sd33, p, sf);
        wait_start(10, c);
        repeat (5) @(negedge ck);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_ready", s_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_fir_in", fir_in, 0);
        chk("arst_timeout_err", timeout_err, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_m_valid", m_valid, 0);
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        got_data.delete();
        sc = start_cnt;
        repeat (40) @(negedge ck);
        chk("arst_no_stale_result", got_data.size(), 0);
        chk("arst_no_stale_start", start_cnt - sc, 0);
        push(-16'sd12345, p, sf);
        wait_mvalid(60, c);
        chk("arst_after_lat", c - p, 22);
        chk("arst_after_data", m_data, 12345);
        repeat (3) @(negedge ck);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
